// File: rtl/regs_bus_arbiter.sv
// Round-robin arbiter sharing the UART register file between two CPU cores.
// One single-cycle we/re strobe per granted access, ack returned two cycles after sampling.
module regs_bus_arbiter #(
    parameter int unsigned       ADDR_W     = 22,
    parameter int unsigned       DATA_W     = 32,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(24)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] r_addr,
    output logic              r_we,
    output logic              r_re,
    output logic [DATA_W-1:0] r_wdata,
    input  logic [DATA_W-1:0] r_rdata,
    output logic              grant
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                pend_err_q, pend_err_d;
    logic                pend_we_q, pend_we_d;
    logic                grant_d;
    logic [ADDR_W-1:0]   r_addr_d;
    logic [DATA_W-1:0]   r_wdata_d;
    logic                r_we_d, r_re_d;
    logic                m0_ack_d, m0_err_d, m1_ack_d, m1_err_d;
    logic [DATA_W-1:0]   m0_rdata_d, m1_rdata_d;
    logic                sel;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic                mapped;

    // Winner select: a lone requester wins, a tie goes to the core that did not win last.
    always_comb begin
        sel      = m1_req & (~m0_req | ~last_q);
        sel_we   = sel ? m1_we : m0_we;
        sel_addr = sel ? m1_addr : m0_addr;
        mapped   = sel_addr < ADDR_LIMIT;
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        pend_err_d = pend_err_q;
        pend_we_d  = pend_we_q;
        grant_d    = grant;
        r_addr_d   = r_addr;
        r_wdata_d  = r_wdata;
        r_we_d     = 1'b0;
        r_re_d     = 1'b0;
        m0_ack_d   = 1'b0;
        m0_err_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m1_err_d   = 1'b0;
        m0_rdata_d = m0_rdata;
        m1_rdata_d = m1_rdata;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_d    = ACCESS;
                    grant_d    = sel;
                    last_d     = sel;
                    r_addr_d   = sel_addr;
                    r_wdata_d  = sel ? m1_wdata : m0_wdata;
                    r_we_d     = mapped & sel_we;
                    r_re_d     = mapped & ~sel_we;
                    pend_err_d = ~mapped;
                    pend_we_d  = sel_we;
                end
            end
            ACCESS: begin
                // Read data is captured at the same edge that closes the strobe.
                state_d = RESP;
                if (!grant) begin
                    m0_ack_d = 1'b1;
                    m0_err_d = pend_err_q;
                    if (!pend_we_q) m0_rdata_d = pend_err_q ? '0 : r_rdata;
                end else begin
                    m1_ack_d = 1'b1;
                    m1_err_d = pend_err_q;
                    if (!pend_we_q) m1_rdata_d = pend_err_q ? '0 : r_rdata;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            pend_err_q <= 1'b0;
            pend_we_q  <= 1'b0;
            grant      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_re       <= 1'b0;
            m0_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m0_rdata   <= '0;
            m1_ack     <= 1'b0;
            m1_err     <= 1'b0;
            m1_rdata   <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            pend_err_q <= pend_err_d;
            pend_we_q  <= pend_we_d;
            grant      <= grant_d;
            r_addr     <= r_addr_d;
            r_wdata    <= r_wdata_d;
            r_we       <= r_we_d;
            r_re       <= r_re_d;
            m0_ack     <= m0_ack_d;
            m0_err     <= m0_err_d;
            m0_rdata   <= m0_rdata_d;
            m1_ack     <= m1_ack_d;
            m1_err     <= m1_err_d;
            m1_rdata   <= m1_rdata_d;
        end
    end

endmodule

// File: tb/tb_regs_bus_arbiter.sv
// Directed bench for regs_bus_arbiter: vector table of single accesses plus
// hand-written tie, fairness and reset-abort sequences against a small register-file model.
module tb_regs_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [21:0] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [21:0] r_addr;
    logic        r_we, r_re, grant;
    logic [31:0] r_wdata, r_rdata;

    regs_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .r_addr(r_addr), .r_we(r_we), .r_re(r_re), .r_wdata(r_wdata),
        .r_rdata(r_rdata), .grant(grant)
    );

    always #5 clk = ~clk;

    // Register-file model: 24 words, combinational read, write on the strobe edge.
    logic [31:0] mem [0:23];
    assign r_rdata = (r_addr < 22'd24) ? mem[r_addr[4:0]] : 32'hDEAD_BEEF;
    always @(posedge clk) if (r_we && r_addr < 22'd24) mem[r_addr[4:0]] <= r_wdata;

    // Event monitor; tests work on deltas of these counters.
    int   we_cnt = 0, re_cnt = 0, both_cnt = 0, b2b_cnt = 0, ack0_cnt = 0, ack1_cnt = 0;
    logic prev_strobe = 1'b0;
    logic glog [$];
    always @(posedge clk) begin
        if (r_we) we_cnt <= we_cnt + 1;
        if (r_re) re_cnt <= re_cnt + 1;
        if (r_we && r_re) both_cnt <= both_cnt + 1;
        if ((r_we || r_re) && prev_strobe) b2b_cnt <= b2b_cnt + 1;
        prev_strobe <= r_we | r_re;
        if (m0_ack) ack0_cnt <= ack0_cnt + 1;
        if (m1_ack) ack1_cnt <= ack1_cnt + 1;
        if (r_we || r_re) glog.push_back(grant);
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    typedef struct {
        logic        m;
        logic        we;
        logic [21:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    task automatic set_req(input logic m, input logic on, input logic we,
                           input logic [21:0] addr, input logic [31:0] wdata);
        if (!m) begin m0_req = on; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
        else    begin m1_req = on; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
    endtask

    // One access from a single core; called 1 time unit after a rising edge, state IDLE.
    task automatic run_vec(input int idx, input vec_t v);
        int   bwe = we_cnt, bre = re_cnt, ba0 = ack0_cnt, ba1 = ack1_cnt;
        int   n = 0;
        logic got = 1'b0, g_err = 1'b0, g_grant = 1'b0;
        logic [31:0] g_rdata = '0;
        string s = $sformatf("v%0d", idx);
        set_req(v.m, 1'b1, v.we, v.addr, v.wdata);
        while (n < 8 && !got) begin
            @(posedge clk); #1; n++;
            if ((v.m ? m1_ack : m0_ack) === 1'b1) begin
                got = 1'b1;
                g_err = v.m ? m1_err : m0_err;
                g_rdata = v.m ? m1_rdata : m0_rdata;
                g_grant = grant;
            end
        end
        set_req(v.m, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        chk({s, "_latency"}, 32'(n), 32'd2);
        chk({s, "_err"}, 32'(g_err), 32'(v.err));
        chk({s, "_rdata"}, g_rdata, v.rdata);
        chk({s, "_grant"}, 32'(g_grant), 32'(v.m));
        chk({s, "_we_strobes"}, 32'(we_cnt - bwe), 32'(v.we && !v.err));
        chk({s, "_re_strobes"}, 32'(re_cnt - bre), 32'(!v.we && !v.err));
        chk({s, "_own_acks"}, 32'(v.m ? ack1_cnt - ba1 : ack0_cnt - ba0), 32'd1);
        chk({s, "_other_acks"}, 32'(v.m ? ack0_cnt - ba0 : ack1_cnt - ba1), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string s);
        chk({s, "_r_we"}, 32'(r_we), 32'd0);
        chk({s, "_r_re"}, 32'(r_re), 32'd0);
        chk({s, "_r_addr"}, 32'(r_addr), 32'd0);
        chk({s, "_r_wdata"}, r_wdata, 32'd0);
        chk({s, "_grant"}, 32'(grant), 32'd0);
        chk({s, "_acks"}, 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
        chk({s, "_rdata"}, m0_rdata | m1_rdata, 32'd0);
    endtask

    task automatic wait_ack(input logic m, input string s, output logic ok);
        int n = 0;
        ok = 1'b0;
        while (n < 12 && !ok) begin
            @(posedge clk); #1; n++;
            if ((m ? m1_ack : m0_ack) === 1'b1) ok = 1'b1;
        end
        chk({s, "_ack_seen"}, 32'(ok), 32'd1);
    endtask

    vec_t vecs [12];

    initial begin
        logic ok;
        int   bre, bg, bb2b, bboth, bwe, ba0, ba1;
        //          m     we    addr        wdata          err   rdata
        vecs[0]  = '{1'b0, 1'b1, 22'h00,     32'h0000_1234, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 22'h00,     32'h0,         1'b0, 32'h0000_1234};
        vecs[2]  = '{1'b0, 1'b1, 22'h03,     32'h0000_0333, 1'b0, 32'h0000_1234};
        vecs[3]  = '{1'b1, 1'b1, 22'h07,     32'h0000_0777, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 22'h17,     32'hCAFE_0017, 1'b0, 32'h0000_1234};
        vecs[5]  = '{1'b0, 1'b0, 22'h17,     32'h0,         1'b0, 32'hCAFE_0017};
        vecs[6]  = '{1'b1, 1'b0, 22'h18,     32'h0,         1'b1, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 22'h17,     32'h0,         1'b0, 32'hCAFE_0017};
        vecs[8]  = '{1'b1, 1'b1, 22'h05,     32'h0000_00A5, 1'b0, 32'hCAFE_0017};
        vecs[9]  = '{1'b0, 1'b0, 22'h05,     32'h0,         1'b0, 32'h0000_00A5};
        vecs[10] = '{1'b0, 1'b1, 22'h18,     32'hBAD0_0000, 1'b1, 32'h0000_00A5};
        vecs[11] = '{1'b1, 1'b0, 22'h3FFFFF, 32'h0,         1'b1, 32'h0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset_outputs("por");

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Tie right after reset: core0 first, then core1, one read strobe each.
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        chk_reset_outputs("rst2");
        bre = re_cnt; bg = glog.size();
        set_req(1'b0, 1'b1, 1'b0, 22'h03, '0);
        set_req(1'b1, 1'b1, 1'b0, 22'h07, '0);
        wait_ack(1'b0, "tie_m0", ok);
        chk("tie_m0_first", 32'(m1_ack), 32'd0);
        chk("tie_m0_rdata", m0_rdata, 32'h0000_0333);
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        wait_ack(1'b1, "tie_m1", ok);
        chk("tie_m1_rdata", m1_rdata, 32'h0000_0777);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        chk("tie_re_strobes", 32'(re_cnt - bre), 32'd2);
        chk("tie_grant_log_len", 32'(glog.size() - bg), 32'd2);
        if (glog.size() - bg == 2) begin
            chk("tie_grant0", 32'(glog[bg]), 32'd0);
            chk("tie_grant1", 32'(glog[bg + 1]), 32'd1);
        end

        // Both cores hold req: six accesses must alternate 0,1,0,1,0,1.
        bg = glog.size(); bb2b = b2b_cnt; bboth = both_cnt; ba0 = ack0_cnt; ba1 = ack1_cnt;
        set_req(1'b0, 1'b1, 1'b0, 22'h00, '0);
        set_req(1'b1, 1'b1, 1'b0, 22'h07, '0);
        for (int n = 0; n < 40 && glog.size() < bg + 6; n++) begin
            @(posedge clk); #1;
        end
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk); #1;
        chk("rr_accesses", 32'(glog.size() - bg), 32'd6);
        for (int i = 0; i < 6; i++)
            if (bg + i < glog.size()) chk($sformatf("rr_grant%0d", i), 32'(glog[bg + i]), 32'(i % 2));
        chk("rr_b2b_strobes", 32'(b2b_cnt - bb2b), 32'd0);
        chk("rr_both_strobes", 32'(both_cnt - bboth), 32'd0);
        chk("rr_acks_m0", 32'(ack0_cnt - ba0), 32'd3);
        chk("rr_acks_m1", 32'(ack1_cnt - ba1), 32'd3);

        // Reset while a core0 write strobe is in flight.
        bwe = we_cnt; ba0 = ack0_cnt;
        set_req(1'b0, 1'b1, 1'b1, 22'h01, 32'h0000_0BAD);
        @(posedge clk); #1;
        chk("abort_strobe_up", 32'(r_we), 32'd1);
        rst = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_outputs("abort");
        repeat (4) @(posedge clk); #1;
        chk("abort_no_ack", 32'(ack0_cnt - ba0), 32'd0);
        chk("abort_single_we", 32'(we_cnt - bwe), 32'd1);
        run_vec(100, '{1'b0, 1'b0, 22'h00, 32'h0, 1'b0, 32'h0000_1234});

        chk("never_both_strobes", 32'(both_cnt), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
